wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the value of wb_pc after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ms_valid, input, 1: MEM-stage record present.
REQ-005 SHALL have ws_allowin, output, 1: WB accepts a record this cycle.
REQ-006 SHALL have ms_pc, input, 32: PC of the MEM record.
REQ-007 SHALL have ms_gr_we, input, 1, and ms_dest, input, 5: GPR write enable and destination.
REQ-008 SHALL have ms_result, input, 32: ALU result or load address.
REQ-009 SHALL have ms_load_op, input, 3: load type, encoded per REQ-032.
REQ-010 SHALL have ms_rdata, input, 32: data-RAM read word.
REQ-011 SHALL have ms_rt_value, input, 32: old rt value, used for the lwl/lwr merge.
REQ-012 SHALL have ws_stall, input, 1: external hold of the WB record.
REQ-013 SHALL have rf_we, output, 1; rf_waddr, output, 5; rf_wdata, output, 32: the register-file write port.
REQ-014 SHALL have wb_valid, output, 1, and wb_pc, output, 32: the commit trace for the testbench.
REQ-015 SHALL have commit_cnt, output, 32: count of retired instructions.

Function
REQ-016 SHALL keep one record register (ws_valid, pc, gr_we, dest, final data), with ws_ready_go = !ws_stall and ws_allowin = !ws_valid || ws_ready_go.
REQ-017 SHALL capture a record at the edge where ms_valid && ws_allowin, computing load-aligned data at capture, so the record is presented one cycle after acceptance.
REQ-018 SHALL set ws_valid to 0 at an edge where the held record retires (ws_valid && ws_ready_go) and no new record is accepted.
REQ-019 SHALL replace the record with no bubble when retire and accept occur on the same edge.
REQ-020 SHALL drive wb_valid = ws_valid && ws_ready_go, so a stalled record never reports commit.
REQ-021 SHALL drive rf_we = wb_valid && gr_we && (dest != 0); rf_waddr = dest; rf_wdata = the held data.
REQ-022 SHALL drive wb_pc from the record PC, updating only on capture and holding its value while ws_valid = 0.
REQ-023 SHALL increment commit_cnt by 1 on each edge where wb_valid = 1, wrapping 32'hFFFF_FFFF to 0.
REQ-024 SHALL, with offset = ms_result[1:0] in little-endian order, produce: none = ms_result; lw = ms_rdata; lb/lbu = byte[offset] sign/zero extended; lh/lhu = half[offset[1]] sign/zero extended, with offset[0] ignored.
REQ-025 SHALL keep ws_allowin = 0 while ms_valid = 1 and ws_stall = 1 with ws_valid = 1; the upstream stage holds its record.

Reset
REQ-026 SHALL, when reset = 1 at an edge, force ws_valid = 0, wb_pc = RESET_PC and commit_cnt = 0.
REQ-027 SHALL, during reset, keep rf_we = 0 and wb_valid = 0; a record held when reset is asserted is dropped and never written.
REQ-028 SHALL ignore ms_valid at any edge where reset = 1.

Configuration
REQ-029 SHALL, with macro LWL_LWR_EN defined, implement lwl: offset 0/1/2/3 gives {rdata[7:0],rt[23:0]}, {rdata[15:0],rt[15:0]}, {rdata[23:0],rt[7:0]}, rdata.
REQ-030 SHALL, with LWL_LWR_EN defined, implement lwr: offset 0/1/2/3 gives rdata, {rt[31:24],rdata[31:8]}, {rt[31:16],rdata[31:16]}, {rt[31:8],rdata[31:24]}.
REQ-031 SHALL, without LWL_LWR_EN, treat the lwl/lwr codes as lw and leave ms_rt_value unused.

Structure
REQ-032 SHALL take the load-op encodings (NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7) and the RESET_PC default from the shared cpu_defs package/header.
REQ-033 SHALL put the data extraction in one combinational sub-module, load_align, instantiated at the capture path.

Verification
REQ-034 SHALL test: lb, result=...0003, rdata=32'h80FF_1234 -> next cycle rf_we=1, rf_wdata=32'hFFFF_FF80.
REQ-035 SHALL test: lhu, result=...0002, rdata=32'h8001_1234 -> rf_wdata=32'h0000_8001.
REQ-036 SHALL test: record held with ws_stall=1 for 3 cycles while ms_valid=1 -> ws_allowin=0, wb_valid=0, no write; on release, one commit, then the next record with no bubble.
REQ-037 SHALL test: with LWL_LWR_EN, lwl at offset 1, rdata=32'hAABB_CCDD, rt=32'h1122_3344 -> rf_wdata=32'hCCDD_3344; without the macro -> 32'hAABB_CCDD.
REQ-038 SHALL test: dest=0 with gr_we=1 -> rf_we=0, wb_valid=1, commit_cnt increments.
REQ-039 SHALL test: reset asserted while ws_valid=1 -> no write, wb_pc=RESET_PC, commit_cnt=0; commit_cnt preloaded to 32'hFFFF_FFFF plus one commit -> 0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, load-op encodings and the reset PC default.
package cpu_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } load_op_e;

endpackage

// File: rtl/wb_stage_pkg.sv
// Write-back stage types: the record held between capture and retire.
package wb_stage_pkg;
  import cpu_defs::*;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              gr_we;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   data;
  } ws_rec_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake and record payload; master is the MEM stage, slave is WB.
interface wb_stage_if;
  import cpu_defs::*;

  logic              ms_valid;
  logic              ws_allowin;
  logic [XLEN-1:0]   ms_pc;
  logic              ms_gr_we;
  logic [REG_AW-1:0] ms_dest;
  logic [XLEN-1:0]   ms_result;
  logic [2:0]        ms_load_op;
  logic [XLEN-1:0]   ms_rdata;
  logic [XLEN-1:0]   ms_rt_value;

  modport master (
    output ms_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
           ms_load_op, ms_rdata, ms_rt_value,
    input  ws_allowin
  );

  modport slave (
    input  ms_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
           ms_load_op, ms_rdata, ms_rt_value,
    output ws_allowin
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Load data extraction (little-endian). Define LWL_LWR_EN to enable lwl/lwr merging;
// otherwise those codes behave as lw.
module load_align
  import cpu_defs::*;
(
  input  logic [2:0]      load_op,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] rt_value,
  output logic [XLEN-1:0] data_c
);

  logic [1:0]  off_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign off_c = result[1:0];

`ifndef LWL_LWR_EN
  logic unused_rt_c;
  assign unused_rt_c = ^rt_value;
`endif

  always_comb begin
    byte_c = rdata[7:0];
    half_c = off_c[1] ? rdata[31:16] : rdata[15:0];
    data_c = result;
    case (off_c)
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      2'd3:    byte_c = rdata[31:24];
      default: byte_c = rdata[7:0];
    endcase
    case (load_op_e'(load_op))
      LD_LB:  data_c = {{24{byte_c[7]}}, byte_c};
      LD_LBU: data_c = {24'h0, byte_c};
      LD_LH:  data_c = {{16{half_c[15]}}, half_c};
      LD_LHU: data_c = {16'h0, half_c};
      LD_LW:  data_c = rdata;
`ifdef LWL_LWR_EN
      // Unaligned word halves merged with the old rt value
      LD_LWL: begin
        case (off_c)
          2'd0:    data_c = {rdata[7:0],  rt_value[23:0]};
          2'd1:    data_c = {rdata[15:0], rt_value[15:0]};
          2'd2:    data_c = {rdata[23:0], rt_value[7:0]};
          default: data_c = rdata;
        endcase
      end
      LD_LWR: begin
        case (off_c)
          2'd0:    data_c = rdata;
          2'd1:    data_c = {rt_value[31:24], rdata[31:8]};
          2'd2:    data_c = {rt_value[31:16], rdata[31:16]};
          default: data_c = {rt_value[31:8],  rdata[31:24]};
        endcase
      end
`else
      LD_LWL, LD_LWR: data_c = rdata;
`endif
      default: data_c = result;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one record register, commit trace and retire counter.
// Optional lwl/lwr support is enabled by defining LWL_LWR_EN.
module wb_stage
  import cpu_defs::*;
  import wb_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  wb_stage_if.slave         ms,
  input  logic              ws_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_pc,
  output logic [XLEN-1:0]   commit_cnt
);

  logic            ws_valid_q, ws_valid_d;
  ws_rec_t         rec_q, rec_d;
  logic [XLEN-1:0] commit_cnt_q, commit_cnt_d;
  logic [XLEN-1:0] align_data_c;
  logic            ready_go_c;
  logic            accept_c;

  load_align u_load_align (
    .load_op  (ms.ms_load_op),
    .result   (ms.ms_result),
    .rdata    (ms.ms_rdata),
    .rt_value (ms.ms_rt_value),
    .data_c   (align_data_c)
  );

  assign ready_go_c    = !ws_stall;
  assign ms.ws_allowin = !ws_valid_q || ready_go_c;
  assign accept_c      = ms.ms_valid && ms.ws_allowin;

  // A record still held while reset is asserted must never report or write
  assign wb_valid   = ws_valid_q && ready_go_c && !reset;
  assign rf_we      = wb_valid && rec_q.gr_we && (rec_q.dest != '0);
  assign rf_waddr   = rec_q.dest;
  assign rf_wdata   = rec_q.data;
  assign wb_pc      = rec_q.pc;
  assign commit_cnt = commit_cnt_q;

  always_comb begin
    ws_valid_d   = ws_valid_q;
    rec_d        = rec_q;
    commit_cnt_d = commit_cnt_q;
    if (accept_c) begin
      ws_valid_d  = 1'b1;
      rec_d.pc    = ms.ms_pc;
      rec_d.gr_we = ms.ms_gr_we;
      rec_d.dest  = ms.ms_dest;
      rec_d.data  = align_data_c;
    end else if (wb_valid) begin
      ws_valid_d = 1'b0;
    end
    if (wb_valid) begin
      commit_cnt_d = commit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q   <= 1'b0;
      rec_q        <= '{pc: RESET_PC, gr_we: 1'b0, dest: '0, data: '0};
      commit_cnt_q <= '0;
    end else begin
      ws_valid_q   <= ws_valid_d;
      rec_q        <= rec_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (honours LWL_LWR_EN when defined).
module tb_wb_stage;
  import cpu_defs::*;

  localparam logic [31:0] TB_RESET_PC = 32'h1C00_0000;
  localparam logic [31:0] RT_VAL      = 32'h1122_3344;
`ifdef LWL_LWR_EN
  localparam logic [31:0] EXP_LWL = 32'hCCDD_3344;
  localparam logic [31:0] EXP_LWR = 32'h1122_AABB;
`else
  localparam logic [31:0] EXP_LWL = 32'hAABB_CCDD;
  localparam logic [31:0] EXP_LWR = 32'hAABB_CCDD;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] result;
    logic [31:0] rdata;
    logic [31:0] expv;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV] = '{
    '{3'(LD_LB),   32'h0000_0003, 32'h80FF_1234, 32'hFFFF_FF80},
    '{3'(LD_LHU),  32'h0000_0002, 32'h8001_1234, 32'h0000_8001},
    '{3'(LD_LBU),  32'h0000_0001, 32'h1234_9A78, 32'h0000_009A},
    '{3'(LD_LH),   32'h0000_0001, 32'h1234_8765, 32'hFFFF_8765},
    '{3'(LD_LW),   32'h0000_0002, 32'hCAFE_F00D, 32'hCAFE_F00D},
    '{3'(LD_NONE), 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF},
    '{3'(LD_LWL),  32'h0000_0001, 32'hAABB_CCDD, EXP_LWL},
    '{3'(LD_LWR),  32'h0000_0002, 32'hAABB_CCDD, EXP_LWR},
    '{3'(LD_LB),   32'h0000_0000, 32'h0000_007F, 32'h0000_007F}
  };

  logic        clk;
  logic        reset;
  logic        ws_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] commit_cnt;

  int n_chk = 0;
  int n_err = 0;

  wb_stage_if ms_if ();

  wb_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .ms         (ms_if),
    .ws_stall   (ws_stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .wb_valid   (wb_valid),
    .wb_pc      (wb_pc),
    .commit_cnt (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] dest,
                       input logic [31:0] res, input logic [2:0] op, input logic [31:0] rd);
    ms_if.ms_valid    = v;
    ms_if.ms_pc       = pc;
    ms_if.ms_gr_we    = we;
    ms_if.ms_dest     = dest;
    ms_if.ms_result   = res;
    ms_if.ms_load_op  = op;
    ms_if.ms_rdata    = rd;
    ms_if.ms_rt_value = RT_VAL;
  endtask

  initial begin
    reset    = 1'b1;
    ws_stall = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 3'(LD_NONE), 32'h0);
    tick();
    tick();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_wb_pc", wb_pc, TB_RESET_PC);
    check("rst_commit_cnt", commit_cnt, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_allowin", 32'(ms_if.ws_allowin), 32'd1);

    // Back-to-back stream: each record replaces the previous with no bubble
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, 32'h1C00_0100 + 32'(4 * i), 1'b1, 5'(i + 1), vecs[i].result, vecs[i].op, vecs[i].rdata);
      tick();
      check($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      check($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'd1);
      check($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(i + 1));
      check($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].expv);
      check($sformatf("v%0d_wb_pc", i), wb_pc, 32'h1C00_0100 + 32'(4 * i));
      check($sformatf("v%0d_commit_cnt", i), commit_cnt, 32'(i));
    end
    ms_if.ms_valid = 1'b0;
    tick();
    check("stream_commit_cnt", commit_cnt, 32'd9);
    check("stream_idle_wb_valid", 32'(wb_valid), 32'd0);
    check("stream_idle_wb_pc", wb_pc, 32'h1C00_0120);

    // Stall: held record blocks upstream for three cycles, then drains without a bubble
    drive(1'b1, 32'h1C00_0200, 1'b1, 5'd7, 32'h0, 3'(LD_LW), 32'h1111_1111);
    tick();
    ws_stall = 1'b1;
    drive(1'b1, 32'h1C00_0204, 1'b1, 5'd8, 32'h0, 3'(LD_LW), 32'h2222_2222);
    #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d_allowin", c), 32'(ms_if.ws_allowin), 32'd0);
      check($sformatf("stall%0d_wb_valid", c), 32'(wb_valid), 32'd0);
      check($sformatf("stall%0d_rf_we", c), 32'(rf_we), 32'd0);
      check($sformatf("stall%0d_wb_pc", c), wb_pc, 32'h1C00_0200);
      check($sformatf("stall%0d_commit_cnt", c), commit_cnt, 32'd9);
    end
    ws_stall = 1'b0;
    #1;
    check("release_wb_valid", 32'(wb_valid), 32'd1);
    check("release_rf_wdata", rf_wdata, 32'h1111_1111);
    check("release_allowin", 32'(ms_if.ws_allowin), 32'd1);
    tick();
    check("next_commit_cnt", commit_cnt, 32'd10);
    check("next_wb_valid", 32'(wb_valid), 32'd1);
    check("next_rf_wdata", rf_wdata, 32'h2222_2222);
    check("next_wb_pc", wb_pc, 32'h1C00_0204);
    ms_if.ms_valid = 1'b0;
    tick();
    check("drain_commit_cnt", commit_cnt, 32'd11);

    // Writes to r0 and with gr_we low still commit but never write
    drive(1'b1, 32'h1C00_0300, 1'b1, 5'd0, 32'h0000_0055, 3'(LD_NONE), 32'h0);
    tick();
    check("r0_wb_valid", 32'(wb_valid), 32'd1);
    check("r0_rf_we", 32'(rf_we), 32'd0);
    drive(1'b1, 32'h1C00_0304, 1'b0, 5'd3, 32'h0000_0066, 3'(LD_NONE), 32'h0);
    tick();
    check("nowe_wb_valid", 32'(wb_valid), 32'd1);
    check("nowe_rf_we", 32'(rf_we), 32'd0);
    check("r0_commit_cnt", commit_cnt, 32'd12);
    ms_if.ms_valid = 1'b0;
    tick();
    check("nowe_commit_cnt", commit_cnt, 32'd13);

    // Reset with a held record: dropped, and ms_valid is ignored at the reset edge
    drive(1'b1, 32'h1C00_0400, 1'b1, 5'd9, 32'h0000_0077, 3'(LD_NONE), 32'h0);
    tick();
    reset = 1'b1;
    #1;
    check("rstheld_rf_we", 32'(rf_we), 32'd0);
    check("rstheld_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    check("rstheld_wb_pc", wb_pc, TB_RESET_PC);
    check("rstheld_commit_cnt", commit_cnt, 32'd0);
    reset = 1'b0;
    ms_if.ms_valid = 1'b0;
    tick();
    check("rstdrop_wb_valid", 32'(wb_valid), 32'd0);
    check("rstdrop_rf_we", 32'(rf_we), 32'd0);
    check("rstdrop_commit_cnt", commit_cnt, 32'd0);

    // Counter wrap from all-ones
    force dut.commit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.commit_cnt_q;
    #1;
    check("preload_commit_cnt", commit_cnt, 32'hFFFF_FFFF);
    drive(1'b1, 32'h1C00_0500, 1'b1, 5'd4, 32'h0000_0088, 3'(LD_NONE), 32'h0);
    tick();
    ms_if.ms_valid = 1'b0;
    tick();
    check("wrap_commit_cnt", commit_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
